// File: rtl/write_mem_stage.sv
// ---------------------------------------------------------------------------
// write_mem_stage
//
// Store-side pipeline stage between execute and retire. Every accepted
// instruction bundle is forwarded with one cycle of latency. Stores with a
// non-zero byte-enable mask are pushed into an in-order store buffer that
// drains to data memory over a valid/ready write channel. When the buffer
// is full the stage stops accepting any bundle, stalling the pipeline.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   in_valid       upstream bundle valid
//   in_ready       stage can accept a bundle (buffer not full)
//   in_addr        instruction word address
//   in_insn        instruction word
//   in_is_store    bundle carries a store
//   in_st_addr     store word address
//   in_st_data     store data
//   in_st_be       store byte enables (all-zero: forwarded, not buffered)
//   out_valid      forwarded bundle valid
//   out_addr       forwarded instruction address
//   out_insn       forwarded instruction word
//   mem_wr_valid   write request valid (buffer not empty)
//   mem_wr_ready   memory accepts the head write
//   mem_wr_addr    head entry address
//   mem_wr_data    head entry data
//   mem_wr_be      head entry byte enables
//   sb_empty       no pending stores
//   sb_count       number of occupied buffer entries
// ---------------------------------------------------------------------------
module write_mem_stage #(
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned INSN_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SB_DEPTH   = 4,
  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8,
  localparam int unsigned CNT_W     = $clog2(SB_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [INSN_WIDTH-1:0] in_insn,
  input  logic                  in_is_store,
  input  logic [ADDR_WIDTH-1:0] in_st_addr,
  input  logic [DATA_WIDTH-1:0] in_st_data,
  input  logic [BE_WIDTH-1:0]   in_st_be,

  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [INSN_WIDTH-1:0] out_insn,

  output logic                  mem_wr_valid,
  input  logic                  mem_wr_ready,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [BE_WIDTH-1:0]   mem_wr_be,

  output logic                  sb_empty,
  output logic [CNT_W-1:0]      sb_count
);

  localparam int unsigned PTR_W = $clog2(SB_DEPTH);

  // Store buffer storage; contents are deliberately not reset.
  logic [ADDR_WIDTH-1:0] sb_addr [SB_DEPTH];
  logic [DATA_WIDTH-1:0] sb_data [SB_DEPTH];
  logic [BE_WIDTH-1:0]   sb_be   [SB_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic full;
  logic empty;
  logic accept;
  logic push;
  logic pop;

  // Status flags come straight from the registered count, so in_ready and
  // mem_wr_valid have no combinational dependency on in_valid/mem_wr_ready.
  assign full     = (count == CNT_W'(SB_DEPTH));
  assign empty    = (count == '0);
  assign in_ready = ~full;
  assign sb_empty = empty;
  assign sb_count = count;

  // The write request is masked during reset so that stores being discarded
  // can never be handed to memory in the reset cycle itself.
  assign mem_wr_valid = ~empty & ~rst;
  assign mem_wr_addr  = sb_addr[rd_ptr];
  assign mem_wr_data  = sb_data[rd_ptr];
  assign mem_wr_be    = sb_be[rd_ptr];

  assign accept = in_valid & in_ready & ~rst;
  assign push   = accept & in_is_store & (in_st_be != '0);
  assign pop    = mem_wr_valid & mem_wr_ready;

  // Forward path: one-cycle latency, no downstream backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      out_addr <= in_addr;
      out_insn <= in_insn;
    end
  end

  // Buffer bookkeeping. Pointers are PTR_W bits wide and wrap naturally
  // because SB_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // A push never targets the head slot while it is being presented, since a
  // push only happens when not full and the head is then a different slot.
  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr[wr_ptr] <= in_st_addr;
      sb_data[wr_ptr] <= in_st_data;
      sb_be[wr_ptr]   <= in_st_be;
    end
  end

endmodule
